core_imem_rsp: RTL and testbench



---
 rtl/core_imem_rsp.sv | 115 +++++++++++
 tb/tb_core_imem_rsp.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/core_imem_rsp.sv
// core_imem_rsp: instruction-memory responder, the slave end of the fetch bus.
//   Accepts one word read per cycle and never stalls. Each request returns exactly one
//   response pulse, in request order, LATENCY cycles later. A side port preloads the array.
// Ports: clk/rst (async, active high); bus_req_valid/bus_req_addr (request);
//   bus_rsp_valid/bus_rsp_data (response; data holds between pulses);
//   imem_wr_en/imem_wr_addr/imem_wr_data (preload write); imem_pend_cnt (requests in flight).
// Optional: define IMEM_RSP_ERR_EN to add bus_rsp_err, which flags misaligned/out-of-range
//   accesses. Without it, such accesses simply return NOP_INST.
module core_imem_rsp #(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013,
  localparam int         CW        = $clog2(LATENCY + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bus_req_valid,
  input  logic [31:0]   bus_req_addr,
  output logic          bus_rsp_valid,
  output logic [31:0]   bus_rsp_data,
`ifdef IMEM_RSP_ERR_EN
  output logic          bus_rsp_err,
`endif
  input  logic          imem_wr_en,
  input  logic [31:0]   imem_wr_addr,
  input  logic [31:0]   imem_wr_data,
  output logic [CW-1:0] imem_pend_cnt
);

  localparam int          AW   = $clog2(DEPTH);
  // Byte span of the array; 33 bits so a full 4 GiB span still compares correctly.
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  logic [31:0] mem [DEPTH];

  // Offsets wrap modulo 2^32, so addresses below BASE_ADDR land far out of range.
  logic [31:0]   rd_off, wr_off;
  logic [AW-1:0] rd_idx, wr_idx;
  logic          rd_bad, wr_ok, wr_hit;

  assign rd_off = bus_req_addr - BASE_ADDR;
  assign wr_off = imem_wr_addr - BASE_ADDR;
  assign rd_idx = rd_off[AW+1:2];
  assign wr_idx = wr_off[AW+1:2];
  // BASE_ADDR is word aligned, so the raw address low bits give the alignment.
  assign rd_bad = (bus_req_addr[1:0] != 2'b00) || ({1'b0, rd_off} >= SPAN);
  assign wr_ok  = (imem_wr_addr[1:0] == 2'b00) && ({1'b0, wr_off} < SPAN);
  // Write-first: a read of the word being written this cycle sees the new data.
  assign wr_hit = imem_wr_en && wr_ok && (wr_idx == rd_idx);

  // Array contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (imem_wr_en && wr_ok) begin
      mem[wr_idx] <= imem_wr_data;
    end
  end

  // Slot 0 is the synchronous array read; slots 1..LATENCY-1 form a {valid, data}
  // shift register. Data only advances behind a valid bit, so bubbles leave the
  // last data in place and the output holds between pulses.
  logic [LATENCY-1:0] vld;
  logic [31:0]        dat [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        dat[k] <= '0;
      end
    end else begin
      vld[0] <= bus_req_valid;
      if (bus_req_valid) begin
        dat[0] <= rd_bad ? NOP_INST : (wr_hit ? imem_wr_data : mem[rd_idx]);
      end
      for (int k = 1; k < LATENCY; k++) begin
        vld[k] <= vld[k-1];
        if (vld[k-1]) begin
          dat[k] <= dat[k-1];
        end
      end
    end
  end

  assign bus_rsp_valid = vld[LATENCY-1];
  assign bus_rsp_data  = dat[LATENCY-1];

`ifdef IMEM_RSP_ERR_EN
  // The error flag is qualified by the request valid at entry, so it can only
  // be high together with a response pulse.
  logic [LATENCY-1:0] err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= '0;
    end else begin
      err[0] <= bus_req_valid && rd_bad;
      for (int k = 1; k < LATENCY; k++) begin
        err[k] <= err[k-1];
      end
    end
  end

  assign bus_rsp_err = err[LATENCY-1];
`endif

  // In-flight count is the population of valid slots, including the output slot.
  always_comb begin
    imem_pend_cnt = '0;
    for (int k = 0; k < LATENCY; k++) begin
      imem_pend_cnt = imem_pend_cnt + CW'(vld[k]);
    end
  end

endmodule

// File: tb/tb_core_imem_rsp.sv
// Self-checking bench for core_imem_rsp: a LATENCY=2 instance and a LATENCY=1
// instance share all inputs; expected values are hand-computed constants.
module tb_core_imem_rsp;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        wr_en;
  logic [31:0] wr_addr, wr_data;

  logic        v2, v1;
  logic [31:0] d2, d1;
  logic [1:0]  c2;
  logic        c1;
`ifdef IMEM_RSP_ERR_EN
  logic        e2, e1;
`endif

  core_imem_rsp #(.DEPTH(1024), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst),
    .bus_req_valid(req_valid), .bus_req_addr(req_addr),
    .bus_rsp_valid(v2), .bus_rsp_data(d2),
`ifdef IMEM_RSP_ERR_EN
    .bus_rsp_err(e2),
`endif
    .imem_wr_en(wr_en), .imem_wr_addr(wr_addr), .imem_wr_data(wr_data),
    .imem_pend_cnt(c2)
  );

  core_imem_rsp #(.DEPTH(1024), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .bus_req_valid(req_valid), .bus_req_addr(req_addr),
    .bus_rsp_valid(v1), .bus_rsp_data(d1),
`ifdef IMEM_RSP_ERR_EN
    .bus_rsp_err(e1),
`endif
    .imem_wr_en(wr_en), .imem_wr_addr(wr_addr), .imem_wr_data(wr_data),
    .imem_pend_cnt(c1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // One isolated request; checks both instances over the following three cycles.
  task automatic run_req(input logic [31:0] a, input logic [31:0] exp, input logic e);
    req_valid = 1'b1; req_addr = a;
    step();
    req_valid = 1'b0;
    chk("l2_not_yet",  32'(v2), 32'd0);
    chk("l2_cnt_a",    32'(c2), 32'd1);
    chk("l1_valid",    32'(v1), 32'd1);
    chk("l1_data",     d1, exp);
    chk("l1_cnt",      32'(c1), 32'd1);
`ifdef IMEM_RSP_ERR_EN
    chk("l1_err",      32'(e1), 32'(e));
`endif
    step();
    chk("l2_valid",    32'(v2), 32'd1);
    chk("l2_data",     d2, exp);
    chk("l2_cnt_b",    32'(c2), 32'd1);
    chk("l1_pulse",    32'(v1), 32'd0);
    chk("l1_cnt_idle", 32'(c1), 32'd0);
`ifdef IMEM_RSP_ERR_EN
    chk("l2_err",      32'(e2), 32'(e));
    chk("l1_err_idle", 32'(e1), 32'd0);
`else
    if (e) begin end
`endif
    step();
    chk("l2_pulse",    32'(v2), 32'd0);
    chk("l2_cnt_idle", 32'(c2), 32'd0);
    chk("l2_hold",     d2, exp);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{32'h0000_0008, 32'h0000_006f, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h0050_0093, 1'b0};  // dropped write at 0x1000 must not alias
    vecs[2] = '{32'h0000_0004, 32'h0010_8113, 1'b0};  // dropped misaligned write at 0x5
    vecs[3] = '{32'h0000_000c, 32'hdead_beef, 1'b0};
    vecs[4] = '{32'h0000_0002, 32'h0000_0013, 1'b1};  // misaligned
    vecs[5] = '{32'h0000_1000, 32'h0000_0013, 1'b1};  // first word past the end
    vecs[6] = '{32'h0000_0ffc, 32'hcafe_f00d, 1'b0};  // last word
    vecs[7] = '{32'hffff_fffc, 32'h0000_0013, 1'b1};  // far out of range

    rst = 1'b1; req_valid = 1'b0; req_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    step(); step();
    chk("rst_v2", 32'(v2), 32'd0);
    chk("rst_d2", d2, 32'd0);
    chk("rst_c2", 32'(c2), 32'd0);
    chk("rst_v1", 32'(v1), 32'd0);
    chk("rst_d1", d1, 32'd0);
`ifdef IMEM_RSP_ERR_EN
    chk("rst_e2", 32'(e2), 32'd0);
`endif
    rst = 1'b0;
    step();

    preload(32'h0000_0000, 32'h0050_0093);
    preload(32'h0000_0004, 32'h0010_8113);
    preload(32'h0000_0008, 32'h0000_006f);
    preload(32'h0000_000c, 32'hdead_beef);
    preload(32'h0000_0ffc, 32'hcafe_f00d);
    preload(32'h0000_1000, 32'h0bad_0bad);
    preload(32'h0000_0005, 32'h0bad_0bad);

    for (int i = 0; i < 8; i++) begin
      run_req(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_err);
    end

    // Back-to-back requests on the LATENCY=2 instance.
    req_valid = 1'b1; req_addr = 32'h0;
    step(); req_addr = 32'h4;
    chk("b2b_cnt1", 32'(c2), 32'd1);
    step(); req_addr = 32'hc;
    chk("b2b_v0", 32'(v2), 32'd1);
    chk("b2b_d0", d2, 32'h0050_0093);
    chk("b2b_cnt2", 32'(c2), 32'd2);
    step(); req_valid = 1'b0;
    chk("b2b_v1", 32'(v2), 32'd1);
    chk("b2b_d1", d2, 32'h0010_8113);
    chk("b2b_cnt_peak", 32'(c2), 32'd2);
    step();
    chk("b2b_v2", 32'(v2), 32'd1);
    chk("b2b_d2", d2, 32'hdead_beef);
    chk("b2b_cnt_drain", 32'(c2), 32'd1);
    step();
    chk("b2b_end", 32'(v2), 32'd0);
    chk("b2b_cnt0", 32'(c2), 32'd0);

    // Continuous stream on the LATENCY=1 instance.
    req_valid = 1'b1; req_addr = 32'h0;
    step(); req_addr = 32'h4;
    chk("l1s_v0", 32'(v1), 32'd1);
    chk("l1s_d0", d1, 32'h0050_0093);
    step(); req_addr = 32'h8;
    chk("l1s_v1", 32'(v1), 32'd1);
    chk("l1s_d1", d1, 32'h0010_8113);
    chk("l1s_cnt", 32'(c1), 32'd1);
    step(); req_addr = 32'hc;
    chk("l1s_v2", 32'(v1), 32'd1);
    chk("l1s_d2", d1, 32'h0000_006f);
    chk("l2s_cnt_full", 32'(c2), 32'd2);
    step(); req_valid = 1'b0;
    chk("l1s_v3", 32'(v1), 32'd1);
    chk("l1s_d3", d1, 32'hdead_beef);
    step();
    chk("l1s_end", 32'(v1), 32'd0);
    chk("l1s_hold", d1, 32'hdead_beef);
    step();

    // Same-cycle write and read of one word: the read returns the new data.
    req_valid = 1'b1; req_addr = 32'h4;
    wr_en = 1'b1; wr_addr = 32'h4; wr_data = 32'h1234_5678;
    step();
    req_valid = 1'b0; wr_en = 1'b0;
    chk("byp_l1_data", d1, 32'h1234_5678);
    step();
    chk("byp_l2_valid", 32'(v2), 32'd1);
    chk("byp_l2_data", d2, 32'h1234_5678);
    step();
    run_req(32'h4, 32'h1234_5678, 1'b0);

    // Reset while two requests are in flight: neither response may appear.
    req_valid = 1'b1; req_addr = 32'h0;
    step(); req_addr = 32'h4;
    #1 rst = 1'b1;
    #1 chk("rst_mid_cnt", 32'(c2), 32'd0);
    chk("rst_mid_v2", 32'(v2), 32'd0);
    step();
    rst = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_no_late_l2", 32'(v2), 32'd0);
      chk("rst_no_late_l1", 32'(v1), 32'd0);
      chk("rst_cnt_zero", 32'(c2), 32'd0);
      step();
    end
    run_req(32'h8, 32'h0000_006f, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
